// File: rtl/scan_sequenced_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : scan_sequenced_shift_register
//  Description : Sequenced serial shift register with a capture/shift/update
//                shadow stage and a test scan path that overrides the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module scan_sequenced_shift_register #(
    parameter int WIDTH       = 8,
    parameter int MSB_FIRST   = 1,
    parameter int AUTO_UPDATE = 1,
    localparam int LEN_W      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_start,
    input  logic [LEN_W-1:0] shift_len,
    input  logic             update,
    input  logic             abort,
    input  logic             shift_in,
    output logic             shift_out,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    input  logic             scan_enable,
    input  logic             scan_in,
    output logic             scan_out
);

    localparam logic [LEN_W-1:0] c_width_len = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] c_one       = LEN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift_reg;
    logic [WIDTH-1:0]   r_data_out;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_done;

    logic [WIDTH-1:0]   w_scan_next;
    logic [WIDTH-1:0]   w_shift_next;
    logic [LEN_W-1:0]   w_len_eff;

    // The scan chain always moves toward the MSB so scan_out is a fixed tap.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_scan_next  = scan_in;
            assign w_shift_next = shift_in;
            assign shift_out    = r_shift_reg[0];
        end else begin : g_wn
            assign w_scan_next = {r_shift_reg[WIDTH-2:0], scan_in};
            if (MSB_FIRST != 0) begin : g_msb
                assign w_shift_next = {r_shift_reg[WIDTH-2:0], shift_in};
                assign shift_out    = r_shift_reg[WIDTH-1];
            end else begin : g_lsb
                assign w_shift_next = {shift_in, r_shift_reg[WIDTH-1:1]};
                assign shift_out    = r_shift_reg[0];
            end
        end
    endgenerate

    assign w_len_eff = ((shift_len == '0) || (shift_len > c_width_len)) ? c_width_len : shift_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift_reg <= '0;
            r_data_out  <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
        end else if (scan_enable) begin
            r_shift_reg <= w_scan_next;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (capture) begin
                        r_shift_reg <= data_in;
                    end else if (shift_start) begin
                        r_cnt   <= w_len_eff;
                        r_state <= ST_SHIFT;
                    end else if (update) begin
                        r_data_out <= r_shift_reg;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_shift_reg <= w_shift_next;
                        r_cnt       <= r_cnt - c_one;
                        if (r_cnt == c_one) begin
                            if (AUTO_UPDATE != 0) begin
                                r_state <= ST_UPDATE;
                            end else begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                ST_UPDATE: begin
                    r_data_out <= r_shift_reg;
                    r_done     <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign scan_out = r_shift_reg[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_scan_sequenced_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_sequenced_shift_register
//  Description : Self-checking bench for scan_sequenced_shift_register.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scan_sequenced_shift_register;

    logic       clk = 1'b0;
    logic       rst, capture, shift_start, update, abort, shift_in, scan_enable, scan_in;
    logic [7:0] data_in;
    logic [3:0] shift_len;

    logic       sout_a, busy_a, done_a, scout_a;
    logic [7:0] dout_a;
    logic       sout_b, busy_b, done_b, scout_b;
    logic [7:0] dout_b;

    int         checks = 0;
    int         errors = 0;
    logic       mon_a  = 1'b0;
    logic       mon_b  = 1'b0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] last_dout;

    typedef struct {
        logic [7:0] cap;
        logic [3:0] len;
        logic [7:0] sin;
        logic [7:0] exp;
        int         busy;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    scan_sequenced_shift_register #(.WIDTH(8), .MSB_FIRST(1), .AUTO_UPDATE(1)) dut_a (
        .clk(clk), .rst(rst), .capture(capture), .data_in(data_in),
        .shift_start(shift_start), .shift_len(shift_len), .update(update),
        .abort(abort), .shift_in(shift_in), .shift_out(sout_a), .data_out(dout_a),
        .busy(busy_a), .done(done_a), .scan_enable(scan_enable), .scan_in(scan_in),
        .scan_out(scout_a)
    );

    scan_sequenced_shift_register #(.WIDTH(8), .MSB_FIRST(0), .AUTO_UPDATE(0)) dut_b (
        .clk(clk), .rst(rst), .capture(capture), .data_in(data_in),
        .shift_start(shift_start), .shift_len(shift_len), .update(update),
        .abort(abort), .shift_in(shift_in), .shift_out(sout_b), .data_out(dout_b),
        .busy(busy_b), .done(done_b), .scan_enable(scan_enable), .scan_in(scan_in),
        .scan_out(scout_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        capture = 0; data_in = 0; shift_start = 0; shift_len = 0; update = 0;
        abort = 0; shift_in = 0; scan_enable = 0; scan_in = 0;
    endtask

    // Scoreboard: each done pulse must match a queued expected data_out.
    always @(negedge clk) begin
        if (mon_a && done_a === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL done_a_unexpected: got done=1 expected no done (t=%0t)", $time);
            end else begin
                logic [7:0] e;
                e = qa.pop_front();
                if (dout_a !== e) begin
                    errors++;
                    $display("FAIL sb_data_out_a: got %0h expected %0h (t=%0t)", dout_a, e, $time);
                end
            end
        end
        if (mon_b && done_b === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL done_b_unexpected: got done=1 expected no done (t=%0t)", $time);
            end else begin
                logic [7:0] e;
                e = qb.pop_front();
                if (dout_b !== e) begin
                    errors++;
                    $display("FAIL sb_data_out_b: got %0h expected %0h (t=%0t)", dout_b, e, $time);
                end
            end
        end
    end

    task automatic do_capture(input logic [7:0] d);
        capture = 1; data_in = d;
        tick();
        capture = 0;
    endtask

    // Start a shift on dut_a; shift_in stream bits are applied sin[7], sin[6], ...
    task automatic do_shift(input logic [7:0] start_reg, input logic [3:0] len,
                            input logic [7:0] sin, input logic [7:0] exp, input int exp_busy);
        int n, k, bc;
        n = (len == 0 || len > 8) ? 8 : int'(len);
        qa.push_back(exp);
        shift_start = 1; shift_len = len;
        tick();
        shift_start = 0;
        k = 0; bc = 0;
        while (busy_a === 1'b1 && bc < 40) begin
            if (k < n) chk("shift_out_a", sout_a, start_reg[7-k]);
            shift_in = (k < 8) ? sin[7-k] : 1'b0;
            tick();
            bc++; k++;
        end
        shift_in = 0;
        chk("busy_cycles_a", bc, exp_busy);
        chk("done_pulse_a", done_a, 1);
        last_dout = exp;
        @(negedge clk); #1;
        chk("sb_drained_a", qa.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{cap: 8'hA5, len: 4'd0,  sin: 8'h3C, exp: 8'h3C, busy: 9};
        vecs[1] = '{cap: 8'hFF, len: 4'd4,  sin: 8'h00, exp: 8'hF0, busy: 5};
        vecs[2] = '{cap: 8'h0F, len: 4'd1,  sin: 8'h80, exp: 8'h1F, busy: 2};
        vecs[3] = '{cap: 8'h12, len: 4'd9,  sin: 8'h5A, exp: 8'h5A, busy: 9};
        vecs[4] = '{cap: 8'hC3, len: 4'd8,  sin: 8'h00, exp: 8'h00, busy: 9};
        vecs[5] = '{cap: 8'h81, len: 4'd2,  sin: 8'hC0, exp: 8'h07, busy: 3};

        // Reset in the middle of random activity
        idle_inputs();
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            capture = 1'($urandom); data_in = 8'($urandom); shift_start = 1'($urandom);
            shift_len = 4'($urandom); update = 1'($urandom); abort = 1'($urandom);
            shift_in = 1'($urandom); scan_enable = 1'($urandom); scan_in = 1'($urandom);
            if (i >= 10) rst = 1;
            tick();
        end
        rst = 0;
        idle_inputs();
        chk("rst_data_out_a", dout_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_shift_out_a", sout_a, 0);
        chk("rst_scan_out_a", scout_a, 0);
        chk("rst_data_out_b", dout_b, 0);
        chk("rst_busy_b", busy_b, 0);

        // LSB-first, manual update on dut_b
        mon_b = 1;
        do_capture(8'hA5);
        chk("b_shift_out_0", sout_b, 1);
        qb.push_back(8'h00);
        shift_start = 1; shift_len = 4'd3;
        tick();
        shift_start = 0;
        chk("b_busy", busy_b, 1);
        chk("b_shift_out_0s", sout_b, 1); shift_in = 1; tick();
        chk("b_shift_out_1", sout_b, 0);  shift_in = 1; tick();
        chk("b_shift_out_2", sout_b, 1);  shift_in = 0; tick();
        chk("b_busy_end", busy_b, 0);
        chk("b_done", done_b, 1);
        tick();
        chk("b_done_drop", done_b, 0);
        chk("b_data_out_held", dout_b, 8'h00);
        update = 1; tick(); update = 0;
        chk("b_data_out_update", dout_b, 8'h74);
        chk("b_sb_drained", qb.size(), 0);
        mon_b = 0;
        tick(); tick();
        rst = 1; tick(); rst = 0;
        mon_a = 1;
        last_dout = 8'h00;

        // Table-driven shifts on dut_a
        for (int i = 0; i < 6; i++) begin
            do_capture(vecs[i].cap);
            do_shift(vecs[i].cap, vecs[i].len, vecs[i].sin, vecs[i].exp, vecs[i].busy);
        end

        // Abort on the 4th shift cycle, then an over-length start
        do_capture(8'hF0);
        shift_start = 1; shift_len = 4'd8; tick(); shift_start = 0;
        for (int k = 0; k < 3; k++) begin shift_in = 0; tick(); end
        abort = 1; tick(); abort = 0;
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_data_out", dout_a, last_dout);
        chk("abort_shift_out", sout_a, 1);
        tick();
        chk("abort_done_late", done_a, 0);
        do_shift(8'h80, 4'd12, 8'h3C, 8'h3C, 9);

        // Scan override mid-shift
        do_capture(8'h00);
        qa.push_back(8'h7F);
        shift_start = 1; shift_len = 4'd8; tick(); shift_start = 0;
        shift_in = 1; tick(); tick();
        scan_enable = 1; shift_in = 0;
        for (int k = 0; k < 3; k++) begin
            scan_in = (k != 1);
            tick();
            chk("scan_busy", busy_a, 1);
            chk("scan_done", done_a, 0);
        end
        scan_enable = 0; scan_in = 0;
        chk("scan_data_out_held", dout_a, last_dout);
        chk("scan_out_mid", scout_a, 0);
        begin
            int bc;
            bc = 0;
            shift_in = 1;
            while (busy_a === 1'b1 && bc < 40) begin tick(); bc++; end
            shift_in = 0;
            chk("scan_remaining_cycles", bc, 7);
        end
        chk("scan_done_end", done_a, 1);
        @(negedge clk); #1;
        chk("scan_sb_drained", qa.size(), 0);
        last_dout = 8'h7F;
        tick();

        // Simultaneous capture/start/update: only capture acts
        do_capture(8'h11);
        capture = 1; data_in = 8'h96; shift_start = 1; shift_len = 4'd8; update = 1;
        tick();
        idle_inputs();
        chk("prio_busy", busy_a, 0);
        chk("prio_data_out", dout_a, 8'h7F);
        chk("prio_shift_out", sout_a, 1);
        tick();
        chk("prio_no_done", done_a, 0);
        do_shift(8'h96, 4'd8, 8'h00, 8'h00, 9);
        do_shift(8'h00, 4'd2, 8'hC0, 8'h03, 3);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
